// File: rtl/wb_bram_tester.sv
// wb_bram_tester: Wishbone B4 pipelined initiator that self-tests one BRAM port.
// On i_start it writes word(a) = a ^ SEED to addresses 0..DEPTH-1. It waits for
// every write to be acknowledged, then reads the same range back. Each read is
// compared in order against the pattern, and the result is reported.
//
// Ports
//   i_clk, i_reset_n    clock, synchronous active-low reset
//   i_start             start request (honoured only in IDLE or DONE)
//   o_busy / o_done     test running / finished (done held until next start)
//   o_pass              done with zero errors and no abort
//   o_err_count         read mismatches plus bus errors, saturating
//   o_timeout           watchdog abort flag
//   o_wb_*              Wishbone master request side (cyc, stb, we, addr, data, sel)
//   i_wb_stall/ack/data/err  Wishbone slave response side
//
// Optional feature: define WB_BRAM_TESTER_TIMEOUT_EN to enable an ack watchdog.
// The watchdog aborts the run after TMO cycles without progress.
module wb_bram_tester #(
  parameter int              AW    = 4,
  parameter int              DW    = 8,
  parameter int              DEPTH = 16,
  parameter logic [DW-1:0]   SEED  = 8'hA5,
  parameter int              CW    = 8,
  parameter int              TMO   = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [CW-1:0]     o_err_count,
  output logic              o_timeout,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [DW-1:0]     o_wb_data,
  output logic [DW/8-1:0]   o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic [DW-1:0]     i_wb_data,
  input  logic              i_wb_err
);

  typedef enum logic [2:0] {IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return DW'(a) ^ SEED;
  endfunction

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [AW-1:0]   rd_cnt_reg, rd_cnt_next;
  logic [AW:0]     outst_reg, outst_next;
  logic [CW-1:0]   err_cnt_reg, err_cnt_next;

  logic busy, cyc, stb, accept, resp, last_req, rd_phase, bad;

  assign busy     = (state_reg == WRITE) || (state_reg == WDRAIN) ||
                    (state_reg == READ)  || (state_reg == RDRAIN);
  // The one WDRAIN cycle with nothing outstanding separates the write and
  // read bus cycles.
  assign cyc      = busy && !((state_reg == WDRAIN) && (outst_reg == '0));
  assign stb      = (state_reg == WRITE) || (state_reg == READ);
  assign accept   = stb && !i_wb_stall;
  assign last_req = accept && (addr_reg == LAST);
  // A response with nothing outstanding is stray (e.g. left over from before a
  // reset) and is dropped.
  assign resp     = busy && (outst_reg != '0) && (i_wb_ack || i_wb_err);
  assign rd_phase = (state_reg == READ) || (state_reg == RDRAIN);
  assign bad      = i_wb_err || (rd_phase && (i_wb_data != word_of(rd_cnt_reg)));

`ifdef WB_BRAM_TESTER_TIMEOUT_EN
  localparam int WDW = (TMO < 2) ? 1 : $clog2(TMO);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 1);
  logic [WDW-1:0] wd_reg, wd_next;
  logic           tmo_reg, tmo_next;
`endif

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    rd_cnt_next  = rd_cnt_reg;
    outst_next   = outst_reg;
    err_cnt_next = err_cnt_reg;
`ifdef WB_BRAM_TESTER_TIMEOUT_EN
    wd_next      = wd_reg;
    tmo_next     = tmo_reg;
`endif

    case ({accept, resp})
      2'b10:   outst_next = outst_reg + (AW+1)'(1);
      2'b01:   outst_next = outst_reg - (AW+1)'(1);
      default: outst_next = outst_reg;
    endcase

    if (accept) begin
      addr_next = last_req ? '0 : addr_reg + AW'(1);
    end

    if (resp) begin
      if (rd_phase) begin
        rd_cnt_next = rd_cnt_reg + AW'(1);
      end
      if (bad && (err_cnt_reg != '1)) begin
        err_cnt_next = err_cnt_reg + CW'(1);
      end
    end

    case (state_reg)
      IDLE, DONE: begin
        if (i_start) begin
          state_next   = WRITE;
          addr_next    = '0;
          rd_cnt_next  = '0;
          outst_next   = '0;
          err_cnt_next = '0;
`ifdef WB_BRAM_TESTER_TIMEOUT_EN
          tmo_next     = 1'b0;
`endif
        end
      end
      WRITE:   if (last_req)          state_next = WDRAIN;
      WDRAIN:  if (outst_reg == '0)   state_next = READ;
      READ:    if (last_req)          state_next = RDRAIN;
      RDRAIN:  if (outst_reg == '0)   state_next = DONE;
      default:                        state_next = IDLE;
    endcase

`ifdef WB_BRAM_TESTER_TIMEOUT_EN
    // Count cycles spent waiting on the slave; any response restarts the count.
    if (cyc && ((outst_reg != '0) || (stb && i_wb_stall)) && !resp) begin
      if (wd_reg == WD_LAST) begin
        state_next = DONE;
        tmo_next   = 1'b1;
        outst_next = '0;
        wd_next    = '0;
      end else begin
        wd_next = wd_reg + WDW'(1);
      end
    end else begin
      wd_next = '0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      rd_cnt_reg  <= '0;
      outst_reg   <= '0;
      err_cnt_reg <= '0;
`ifdef WB_BRAM_TESTER_TIMEOUT_EN
      wd_reg      <= '0;
      tmo_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      rd_cnt_reg  <= rd_cnt_next;
      outst_reg   <= outst_next;
      err_cnt_reg <= err_cnt_next;
`ifdef WB_BRAM_TESTER_TIMEOUT_EN
      wd_reg      <= wd_next;
      tmo_reg     <= tmo_next;
`endif
    end
  end

`ifdef WB_BRAM_TESTER_TIMEOUT_EN
  assign o_timeout = tmo_reg;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_busy      = busy;
  assign o_done      = (state_reg == DONE);
  assign o_pass      = (state_reg == DONE) && (err_cnt_reg == '0) && !o_timeout;
  assign o_err_count = err_cnt_reg;
  assign o_wb_cyc    = cyc;
  assign o_wb_stb    = stb;
  assign o_wb_we     = (state_reg == WRITE);
  assign o_wb_addr   = addr_reg;
  // Write data is only meaningful in the write phase. It is zero elsewhere so
  // the bus is quiet in idle and after reset.
  assign o_wb_data   = (state_reg == WRITE) ? word_of(addr_reg) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DW/8; gi++) begin : g_sel
      assign o_wb_sel[gi] = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_wb_bram_tester.sv
// Testbench for wb_bram_tester. A behavioural Wishbone slave with configurable
// stall, latency, read corruption, write error and no-ack modes serves one of
// two instances (CW=8 and CW=1) selected by sel. Expected bus requests and
// results are queued by the stimulus and checked by a monitor.
module tb_wb_bram_tester;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel   = 1'b0;

  logic       s_stall = 1'b0, s_ack = 1'b0, s_err = 1'b0;
  logic [7:0] s_rdata = 8'h00;

  logic       d0_busy, d0_done, d0_pass, d0_tmo, d0_cyc, d0_stb, d0_we;
  logic [3:0] d0_addr;
  logic [7:0] d0_wdata, d0_err;
  logic [0:0] d0_sel;
  logic       d1_busy, d1_done, d1_pass, d1_tmo, d1_cyc, d1_stb, d1_we;
  logic [3:0] d1_addr;
  logic [7:0] d1_wdata;
  logic [0:0] d1_err;
  logic [0:0] d1_sel;

  wb_bram_tester #(.AW(4), .DW(8), .DEPTH(16), .SEED(8'hA5), .CW(8), .TMO(TMO)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start && !sel),
    .o_busy(d0_busy), .o_done(d0_done), .o_pass(d0_pass), .o_err_count(d0_err),
    .o_timeout(d0_tmo), .o_wb_cyc(d0_cyc), .o_wb_stb(d0_stb), .o_wb_we(d0_we),
    .o_wb_addr(d0_addr), .o_wb_data(d0_wdata), .o_wb_sel(d0_sel),
    .i_wb_stall(!sel && s_stall), .i_wb_ack(!sel && s_ack),
    .i_wb_data(s_rdata), .i_wb_err(!sel && s_err));

  wb_bram_tester #(.AW(4), .DW(8), .DEPTH(16), .SEED(8'hA5), .CW(1), .TMO(TMO)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start && sel),
    .o_busy(d1_busy), .o_done(d1_done), .o_pass(d1_pass), .o_err_count(d1_err),
    .o_timeout(d1_tmo), .o_wb_cyc(d1_cyc), .o_wb_stb(d1_stb), .o_wb_we(d1_we),
    .o_wb_addr(d1_addr), .o_wb_data(d1_wdata), .o_wb_sel(d1_sel),
    .i_wb_stall(sel && s_stall), .i_wb_ack(sel && s_ack),
    .i_wb_data(s_rdata), .i_wb_err(sel && s_err));

  logic       m_busy, m_done, m_pass, m_tmo, m_cyc, m_stb, m_we;
  logic [3:0] m_addr;
  logic [7:0] m_wdata, m_err;
  logic [0:0] m_sel;
  assign m_busy  = sel ? d1_busy  : d0_busy;
  assign m_done  = sel ? d1_done  : d0_done;
  assign m_pass  = sel ? d1_pass  : d0_pass;
  assign m_tmo   = sel ? d1_tmo   : d0_tmo;
  assign m_cyc   = sel ? d1_cyc   : d0_cyc;
  assign m_stb   = sel ? d1_stb   : d0_stb;
  assign m_we    = sel ? d1_we    : d0_we;
  assign m_addr  = sel ? d1_addr  : d0_addr;
  assign m_wdata = sel ? d1_wdata : d0_wdata;
  assign m_err   = sel ? {7'b0, d1_err} : d0_err;
  assign m_sel   = sel ? d1_sel   : d0_sel;

  // Hand-computed pattern a ^ 0xA5 for a = 0..15.
  logic [7:0] pat [16] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2,
                           8'hAD, 8'hAC, 8'hAF, 8'hAE, 8'hA9, 8'hA8, 8'hAB, 8'hAA};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  int tcyc = 0;
  always @(posedge clk) tcyc = tcyc + 1;

  // ---------------- behavioural slave ----------------
  typedef struct { int due; logic [7:0] d; logic e; } rsp_t;
  rsp_t        rq[$];
  logic [7:0]  mem [16];
  int          edge_n = 0;
  int          stall_mode = 0, lat = 1, no_ack = 0, err_addr = -1;
  logic [15:0] corrupt = 16'h0000;

  always @(posedge clk) begin
    rsp_t r;
    edge_n = edge_n + 1;
    if (m_cyc && m_stb && !s_stall) begin
      if (no_ack == 0) begin
        r.due = edge_n + lat - 1;
        r.e   = m_we && (int'(m_addr) == err_addr);
        r.d   = m_we ? 8'h00 : (mem[m_addr] ^ (corrupt[m_addr] ? 8'h01 : 8'h00));
        rq.push_back(r);
      end
      if (m_we) mem[m_addr] = m_wdata;
    end
    if (rq.size() > 0 && rq[0].due <= edge_n) begin
      s_ack   <= !rq[0].e;
      s_err   <= rq[0].e;
      s_rdata <= rq[0].d;
      void'(rq.pop_front());
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
    end
    s_stall <= (stall_mode != 0) ? ~s_stall : 1'b0;
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic we; logic [3:0] a; logic [7:0] d; } req_t;
  typedef struct { logic [7:0] err; logic pass; logic tmo; } res_t;
  req_t exp_q[$];
  res_t res_q[$];

  int   acc_total = 0, acc_mark = -1, first_acc_cyc = 0, rd_seen = 0, gap_cnt = 0;
  logic hold_v = 1'b0, done_prev = 1'b0;
  logic [12:0] hold_vec = '0;

  always @(negedge clk) begin
    req_t mr;
    res_t rr;
    if (rst_n) begin
      if (m_stb && !s_stall) begin
        if (acc_total == acc_mark) first_acc_cyc = tcyc;
        acc_total++;
        if (!m_we) rd_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra request: got we=%0d addr=%0d, required none", m_we, m_addr);
        end else begin
          mr = exp_q.pop_front();
          $display("req  we=%0d addr=%0d data=%02h", m_we, m_addr, m_wdata);
          chk("req cyc", 32'(m_cyc), 32'd1);
          chk("req we", 32'(m_we), 32'(mr.we));
          chk("req addr", 32'(m_addr), 32'(mr.a));
          if (mr.we) chk("req data", 32'(m_wdata), 32'(mr.d));
          chk("req sel", 32'(m_sel), 32'd1);
        end
      end
      if (hold_v && m_stb) chk("stall hold", 32'({m_we, m_addr, m_wdata}), 32'(hold_vec));
      hold_v   = m_stb && s_stall;
      hold_vec = {m_we, m_addr, m_wdata};
      if (m_busy && !m_cyc) gap_cnt++;
      if (m_done && !done_prev) begin
        $display("done err=%0d pass=%0d timeout=%0d", m_err, m_pass, m_tmo);
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected done: got done=1, required 0");
        end else begin
          rr = res_q.pop_front();
          chk("result err_count", 32'(m_err), 32'(rr.err));
          chk("result pass", 32'(m_pass), 32'(rr.pass));
          chk("result timeout", 32'(m_tmo), 32'(rr.tmo));
        end
      end
      done_prev = m_done;
    end else begin
      hold_v    = 1'b0;
      done_prev = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  int start_cyc = 0;

  task automatic push_run(input logic [7:0] e_err, input logic e_pass, input logic e_tmo,
                          input bit with_res);
    req_t r;
    res_t s;
    for (int a = 0; a < 16; a++) begin
      r.we = 1'b1; r.a = 4'(a); r.d = pat[a];
      exp_q.push_back(r);
    end
    for (int a = 0; a < 16; a++) begin
      r.we = 1'b0; r.a = 4'(a); r.d = 8'h00;
      exp_q.push_back(r);
    end
    if (with_res) begin
      s.err = e_err; s.pass = e_pass; s.tmo = e_tmo;
      res_q.push_back(s);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    start_cyc = tcyc;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    i = 0;
    while (!m_done && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (!m_done) begin
      checks++;
      errors++;
      $display("FAIL %s done wait: got done=0 after %0d cycles, required 1", name, limit);
    end
  endtask

  task automatic run(input string name, input logic [7:0] e_err, input logic e_pass,
                     input bit chk_lat);
    int g0, latc;
    push_run(e_err, e_pass, 1'b0, 1'b1);
    g0 = gap_cnt;
    pulse_start();
    wait_done(name, 300);
    latc = tcyc - start_cyc;
    @(negedge clk);
    chk({name, " cyc gap"}, 32'(gap_cnt - g0), 32'd1);
    chk({name, " leftover"}, 32'(exp_q.size() + res_q.size()), 32'd0);
    if (chk_lat) begin
      checks++;
      if (latc < 34 || latc > 38) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles, required about 37", name, latc);
      end
    end
    exp_q.delete();
    res_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    res_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " busy"}, 32'(m_busy), 0);
    chk({name, " done"}, 32'(m_done), 0);
    chk({name, " pass"}, 32'(m_pass), 0);
    chk({name, " err"}, 32'(m_err), 0);
    chk({name, " timeout"}, 32'(m_tmo), 0);
    chk({name, " cyc"}, 32'(m_cyc), 0);
    chk({name, " stb"}, 32'(m_stb), 0);
    chk({name, " we"}, 32'(m_we), 0);
    chk({name, " addr"}, 32'(m_addr), 0);
    chk({name, " data"}, 32'(m_wdata), 0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");

    // 1: ideal slave
    stall_mode = 0; lat = 1; corrupt = 16'h0000; err_addr = -1;
    run("t1 ideal", 8'd0, 1'b1, 1'b1);

    // 2: stall every other cycle, latency 3
    stall_mode = 1; lat = 3;
    run("t2 stall", 8'd0, 1'b1, 1'b0);
    stall_mode = 0; lat = 1;
    repeat (4) @(negedge clk);

    // 3: corrupt reads at 3 and 9
    corrupt = 16'h0208;
    run("t3 corrupt", 8'd2, 1'b0, 1'b0);

    // 3b: CW=1 instance, three corruptions saturate at 1
    sel = 1'b1;
    corrupt = 16'h1208;
    run("t3b saturate", 8'd1, 1'b0, 1'b0);
    sel = 1'b0;
    corrupt = 16'h0000;

    // 4: bus error on write to addr 5
    err_addr = 5;
    run("t4 write err", 8'd1, 1'b0, 1'b0);
    err_addr = -1;

    // 5: reset mid-READ with 2 outstanding, late acks still delivered
    lat = 2;
    push_run(8'd0, 1'b0, 1'b0, 1'b0);
    base = rd_seen;
    pulse_start();
    for (int i = 0; i < 100 && rd_seen < base + 4; i++) @(negedge clk);
    chk("t5 reached read", 32'(rd_seen >= base + 4), 1);
    do_reset();
    chk_all_zero("t5 in reset");
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5 late busy", 32'(m_busy), 0);
    chk("t5 late err", 32'(m_err), 0);
    chk("t5 late done", 32'(m_done), 0);
    lat = 1;
    run("t5 restart", 8'd0, 1'b1, 1'b0);

    // 6: slave never acks
    no_ack = 1;
`ifdef WB_BRAM_TESTER_TIMEOUT_EN
    push_run(8'd0, 1'b0, 1'b1, 1'b1);
    acc_mark = acc_total;
    pulse_start();
    wait_done("t6 timeout", 100);
    chk("t6 abort delay", 32'(tcyc - first_acc_cyc - 1), 32'(TMO));
    chk("t6 cyc", 32'(m_cyc), 0);
    chk("t6 timeout", 32'(m_tmo), 1);
    @(negedge clk);
    chk("t6 result popped", 32'(res_q.size()), 0);
    exp_q.delete();
`else
    push_run(8'd0, 1'b0, 1'b0, 1'b0);
    base = acc_total;
    pulse_start();
    repeat (300) @(negedge clk);
    chk("t6 busy held", 32'(m_busy), 1);
    chk("t6 no done", 32'(m_done), 0);
    chk("t6 cyc held", 32'(m_cyc), 1);
    chk("t6 writes issued", 32'(acc_total - base), 32'd16);
    do_reset();
    rst_n = 1'b1;
`endif
    no_ack = 0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global time limit: got no finish, required finish");
    $fatal(1, "time limit");
  end

endmodule
